// File: rtl/rotary_pkg.sv
// Shared types and constants for the rotary encoder front end.
package rotary_pkg;

    typedef enum logic [2:0] {
        StRest = 3'd0,
        StCw1  = 3'd1,
        StCw2  = 3'd2,
        StCw3  = 3'd3,
        StCcw1 = 3'd4,
        StCcw2 = 3'd5,
        StCcw3 = 3'd6
    } rotary_state_e;

    localparam logic       DIR_CW    = 1'b1;
    localparam logic       DIR_CCW   = 1'b0;
    localparam logic [1:0] REST_CODE = 2'b11;

endpackage

// File: rtl/debounce_filter.sv
// Single-phase debouncer: filtered follows raw once raw has differed for
// DEBOUNCE_CYCLES consecutive samples. Filtered output resets high.
module debounce_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic filtered
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (raw != filt_q) begin
            // The edge that would make the count reach DEBOUNCE_CYCLES commits instead.
            if (cnt_q == CNT_LAST) begin
                filt_d = raw;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filtered = filt_q;

endmodule

// File: rtl/rotary_decoder.sv
// Quadrature detent decoder: debounced A/B -> turned strobe, direction, wrapping position.
// Optional illegal-transition counter enabled by ROTARY_DECODER_ERR_CNT_EN.
module rotary_decoder
    import rotary_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned POS_MAX         = 26,
    parameter int unsigned POS_W           = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enc_a,
    input  logic             enc_b,
    output logic             turned,
    output logic             dir,
    output logic [POS_W-1:0] position
`ifdef ROTARY_DECODER_ERR_CNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(POS_MAX - 1);

    logic          fa, fb;
    logic [1:0]    code;
    logic [1:0]    code_q, code_d;
    rotary_state_e state_q, state_d;
    logic          turned_q, turned_d;
    logic          dir_q, dir_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic          illegal;
    logic          cw_done, ccw_done;

    debounce_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_a (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (enc_a),
        .filtered(fa)
    );

    debounce_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_b (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (enc_b),
        .filtered(fb)
    );

    assign code = {fa, fb};

    // The FSM only reacts when the filtered code changes, so a code that stays
    // illegal in REST is flagged once rather than every cycle.
    always_comb begin
        state_d  = state_q;
        code_d   = code;
        illegal  = 1'b0;
        cw_done  = 1'b0;
        ccw_done = 1'b0;
        if (code != code_q) begin
            unique case (state_q)
                StRest: begin
                    case (code)
                        2'b01:   state_d = StCw1;
                        2'b10:   state_d = StCcw1;
                        2'b00:   illegal = 1'b1;
                        default: ;
                    endcase
                end
                StCw1: begin
                    case (code)
                        2'b00:   state_d = StCw2;
                        2'b10:   illegal = 1'b1;
                        default: state_d = StRest;
                    endcase
                end
                StCw2: begin
                    case (code)
                        2'b10:   state_d = StCw3;
                        2'b01:   state_d = StCw1;
                        default: illegal = 1'b1;
                    endcase
                end
                StCw3: begin
                    case (code)
                        REST_CODE: begin
                            state_d = StRest;
                            cw_done = 1'b1;
                        end
                        2'b00:   state_d = StCw2;
                        default: illegal = 1'b1;
                    endcase
                end
                StCcw1: begin
                    case (code)
                        2'b00:   state_d = StCcw2;
                        2'b01:   illegal = 1'b1;
                        default: state_d = StRest;
                    endcase
                end
                StCcw2: begin
                    case (code)
                        2'b01:   state_d = StCcw3;
                        2'b10:   state_d = StCcw1;
                        default: illegal = 1'b1;
                    endcase
                end
                StCcw3: begin
                    case (code)
                        REST_CODE: begin
                            state_d  = StRest;
                            ccw_done = 1'b1;
                        end
                        2'b00:   state_d = StCcw2;
                        default: illegal = 1'b1;
                    endcase
                end
                default: state_d = StRest;
            endcase
            if (illegal) begin
                state_d = StRest;
            end
        end
    end

    always_comb begin
        turned_d = 1'b0;
        dir_d    = dir_q;
        pos_d    = pos_q;
        if (cw_done) begin
            turned_d = 1'b1;
            dir_d    = DIR_CW;
            pos_d    = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
        end else if (ccw_done) begin
            turned_d = 1'b1;
            dir_d    = DIR_CCW;
            pos_d    = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StRest;
            code_q   <= REST_CODE;
            turned_q <= 1'b0;
            dir_q    <= DIR_CCW;
            pos_q    <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            turned_q <= turned_d;
            dir_q    <= dir_d;
            pos_q    <= pos_d;
        end
    end

    assign turned   = turned_q;
    assign dir      = dir_q;
    assign position = pos_q;

`ifdef ROTARY_DECODER_ERR_CNT_EN
    logic [7:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (illegal && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 8'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_rotary_decoder.sv
// Self-checking bench for rotary_decoder: vector table, hand sequences and
// randomized stimulus against a progress-counter reference model.
module tb_rotary_decoder;

    localparam int unsigned DEB  = 4;
    localparam int unsigned PMAX = 26;
    localparam int unsigned PW   = 5;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          enc_a = 1'b1;
    logic          enc_b = 1'b1;
    logic          turned;
    logic          dir;
    logic [PW-1:0] position;
`ifdef ROTARY_DECODER_ERR_CNT_EN
    logic [7:0]    err_count;
`endif

    rotary_decoder #(
        .DEBOUNCE_CYCLES(DEB),
        .POS_MAX        (PMAX),
        .POS_W          (PW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .turned  (turned),
        .dir     (dir),
        .position(position)
`ifdef ROTARY_DECODER_ERR_CNT_EN
        ,
        .err_count(err_count)
`endif
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;
    int pulses = 0;

    typedef struct {
        logic [1:0] code;
        int         hold;
        int         exp_pulses;
        int         exp_dir;
        int         exp_pos;
    } vec_t;

    vec_t tbl[$];

    // Reference model: filtered phases, and detent progress as a signed step
    // count (+4 completes clockwise, -4 completes counter-clockwise).
    bit         m_fa, m_fb;
    int         m_ra, m_rb;
    logic [1:0] m_prev;
    int         m_p;
    bit         m_turned, m_dir;
    int         m_pos, m_err;

    function automatic int gidx(input logic [1:0] c);
        case (c)
            2'b11:   return 0;
            2'b01:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gcode(input int g);
        case (g)
            0:       return 2'b11;
            1:       return 2'b01;
            2:       return 2'b00;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int mod4(input int x);
        return ((x % 4) + 4) % 4;
    endfunction

    task automatic model_reset();
        m_fa = 1; m_fb = 1; m_ra = 0; m_rb = 0;
        m_prev = 2'b11; m_p = 0;
        m_turned = 0; m_dir = 0; m_pos = 0; m_err = 0;
    endtask

    task automatic model_step();
        logic [1:0] cur;
        int d;
        cur = {m_fa, m_fb};
        m_turned = 0;
        if (cur != m_prev) begin
            d = mod4(gidx(cur) - mod4(m_p));
            if (d == 2) begin
                m_p = 0;
                if (m_err < 255) m_err++;
            end else if (d == 1) begin
                m_p++;
            end else if (d == 3) begin
                m_p--;
            end
            if (m_p == 4) begin
                m_p = 0; m_turned = 1; m_dir = 1; m_pos = (m_pos + 1) % PMAX;
            end else if (m_p == -4) begin
                m_p = 0; m_turned = 1; m_dir = 0; m_pos = (m_pos + PMAX - 1) % PMAX;
            end
        end
        m_prev = cur;
        if (enc_a != m_fa) begin
            m_ra++;
            if (m_ra == DEB) begin m_fa = enc_a; m_ra = 0; end
        end else m_ra = 0;
        if (enc_b != m_fb) begin
            m_rb++;
            if (m_rb == DEB) begin m_fb = enc_b; m_rb = 0; end
        end else m_rb = 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cycle();
        @(posedge clock);
        if (reset_n) model_step();
        @(negedge clock);
        if (turned) pulses++;
        check("turned", turned, m_turned);
        check("dir", dir, m_dir);
        check("position", position, m_pos);
`ifdef ROTARY_DECODER_ERR_CNT_EN
        check("err_count", err_count, m_err);
`endif
    endtask

    task automatic hold(input logic [1:0] c, input int n);
        enc_a = c[1];
        enc_b = c[0];
        repeat (n) cycle();
    endtask

    initial begin
        int p0, lat;
        logic [1:0] rc;
        int g;

        model_reset();
        repeat (3) @(negedge clock);
        check("rst_turned", turned, 0);
        check("rst_dir", dir, 0);
        check("rst_position", position, 0);
        reset_n = 1'b1;

        p0 = pulses;
        repeat (100) cycle();
        check("idle_pulses", pulses - p0, 0);
        check("idle_position", position, 0);

        tbl.push_back('{2'b01, 10, 0, 0, 0});
        tbl.push_back('{2'b00, 10, 0, 0, 0});
        tbl.push_back('{2'b10, 10, 0, 0, 0});
        tbl.push_back('{2'b11, 10, 1, 1, 1});
        tbl.push_back('{2'b10, 10, 0, 1, 1});
        tbl.push_back('{2'b00, 10, 0, 1, 1});
        tbl.push_back('{2'b01, 10, 0, 1, 1});
        tbl.push_back('{2'b11, 10, 1, 0, 0});
        tbl.push_back('{2'b10, 10, 0, 0, 0});
        tbl.push_back('{2'b00, 10, 0, 0, 0});
        tbl.push_back('{2'b01, 10, 0, 0, 0});
        tbl.push_back('{2'b11, 10, 1, 0, 25});
        tbl.push_back('{2'b01, 10, 0, 0, 25});
        tbl.push_back('{2'b00, 10, 0, 0, 25});
        tbl.push_back('{2'b10, 10, 0, 0, 25});
        tbl.push_back('{2'b11, 10, 1, 1, 0});
        tbl.push_back('{2'b01, 10, 0, 1, 0});
        tbl.push_back('{2'b00, 10, 0, 1, 0});
        tbl.push_back('{2'b01, 10, 0, 1, 0});
        tbl.push_back('{2'b11, 10, 0, 1, 0});
        tbl.push_back('{2'b00, 10, 0, 1, 0});
        tbl.push_back('{2'b11, 10, 0, 1, 0});

        foreach (tbl[i]) begin
            p0 = pulses;
            hold(tbl[i].code, tbl[i].hold);
            check($sformatf("vec%0d_pulses", i), pulses - p0, tbl[i].exp_pulses);
            check($sformatf("vec%0d_dir", i), dir, tbl[i].exp_dir);
            check($sformatf("vec%0d_pos", i), position, tbl[i].exp_pos);
        end

        // Detent latency: final 11 is first sampled on the next edge, filtered
        // follows DEB-1 edges later, and the registered strobe one edge after that.
        hold(2'b01, 10);
        hold(2'b00, 10);
        hold(2'b10, 10);
        enc_a = 1'b1;
        enc_b = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (turned && lat == 0) lat = k;
        end
        check("cw_latency", lat, DEB + 1);
        check("cw_position", position, 1);
        check("cw_dir", dir, 1);

        // Glitch on A shorter than the debounce window.
        p0 = pulses;
        hold(2'b01, DEB - 1);
        hold(2'b11, 20);
        check("glitch_pulses", pulses - p0, 0);
        check("glitch_position", position, 1);

        // Asynchronous reset in the middle of a detent.
        hold(2'b01, 10);
        hold(2'b00, 10);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_turned", turned, 0);
        check("async_position", position, 0);
        check("async_dir", dir, 0);
        repeat (2) cycle();
        reset_n = 1'b1;
        p0 = pulses;
        hold(2'b10, 10);
        hold(2'b11, 10);
        check("midrst_pulses", pulses - p0, 0);
        check("midrst_position", position, 0);

        p0 = pulses;
        hold(2'b00, 10);
        hold(2'b11, 10);
        check("illegal_pulses", pulses - p0, 0);
        check("illegal_position", position, 0);
`ifdef ROTARY_DECODER_ERR_CNT_EN
        check("illegal_err", err_count, 1);
`endif

        rc = 2'b11;
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 9) < 7) begin
                g = gidx(rc) + (($urandom_range(0, 1) == 1) ? 1 : -1);
                rc = gcode(mod4(g));
            end else begin
                rc = 2'($urandom_range(0, 3));
            end
            hold(rc, $urandom_range(1, 8));
        end
        hold(2'b11, 20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
